// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer and control_unit: states, formats, field positions.
package seq_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 8;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        HALTED = 3'd3,
        PAUSE  = 3'd4
    } seq_state_e;

    // Instruction format field values
    localparam logic [1:0] FMT_R    = 2'b00;
    localparam logic [1:0] FMT_I    = 2'b01;
    localparam logic [1:0] FMT_J    = 2'b10;
    localparam logic [1:0] FMT_HALT = 2'b11;

    // Instruction field positions shared with control_unit
    localparam int unsigned FMT_LSB   = 0;
    localparam int unsigned FMT_MSB   = 1;
    localparam int unsigned RD_LSB    = 2;
    localparam int unsigned RD_MSB    = 4;
    localparam int unsigned RS1_LSB   = 5;
    localparam int unsigned RS1_MSB   = 7;
    localparam int unsigned RS2_LSB   = 8;
    localparam int unsigned RS2_MSB   = 10;
    localparam int unsigned IMM_LSB   = 8;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned JADDR_LSB = 2;
    localparam int unsigned JADDR_MSB = 15;

    // True when the word is a HALT marker
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[FMT_MSB:FMT_LSB] == FMT_HALT;
    endfunction

endpackage

// File: rtl/seq_prog_ram.sv
// Program RAM: DEPTH x 16, synchronous write, registered read with write-through on address match.
module seq_prog_ram
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; a same-cycle write to the read address is forwarded so the reader sees new data
    always_ff @(posedge clk) begin
        if (re) begin
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: issues program RAM words to control_unit over the run/done handshake.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds step_mode/step and a PAUSE state after each done.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               done,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    output logic               run,
    output logic [INSTR_W-1:0] instruction,
    output logic [AW-1:0]      pc,
    output logic [CNT_W-1:0]   instr_count,
    output logic               busy,
    output logic               halted
);

    seq_state_e         state;
    seq_state_e         state_nxt;
    logic [AW-1:0]      pc_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ram_re;
    logic [INSTR_W-1:0] ram_rdata;
    logic               prog_ok_c;
    logic               run_d;
    logic               busy_d;
    logic               halted_d;
    logic [INSTR_W-1:0] instr_d;

    // Program loading is only accepted while the sequencer is not executing
    assign prog_ok_c = (state == IDLE) || (state == HALTED);

    seq_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we & prog_ok_c),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (ram_re),
        .raddr (pc_nxt),
        .rdata (ram_rdata)
    );

    // State, pc and completed-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_count <= cnt_nxt;
        end
    end

    // Next state, next pc and counter; the RAM is read on entry to FETCH so its data is ready there
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = instr_count;
        unique case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nxt = FETCH;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            FETCH: begin
                state_nxt = is_halt(ram_rdata) ? HALTED : ISSUE;
            end
            ISSUE: begin
                if (done && run) begin
                    cnt_nxt = (instr_count == {CNT_W{1'b1}}) ? instr_count
                                                             : instr_count + CNT_W'(1);
                    if (pc == AW'(DEPTH - 1)) begin
                        state_nxt = HALTED;
                    end else begin
                        pc_nxt = pc + AW'(1);
`ifdef SEQ_SINGLE_STEP_EN
                        state_nxt = step_mode ? PAUSE : FETCH;
`else
                        state_nxt = FETCH;
`endif
                    end
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            PAUSE: begin
                if (!step_mode || step) begin
                    state_nxt = FETCH;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
        ram_re = (state_nxt == FETCH);
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        run_d    = (state_nxt == ISSUE);
        busy_d   = (state_nxt == FETCH) || (state_nxt == ISSUE) || (state_nxt == PAUSE);
        halted_d = (state_nxt == HALTED);
        instr_d  = instruction;
        if ((state == FETCH) && (state_nxt == ISSUE)) begin
            instr_d = ram_rdata;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            run         <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            instruction <= '0;
        end else begin
            run         <= run_d;
            busy        <= busy_d;
            halted      <= halted_d;
            instruction <= instr_d;
        end
    end

endmodule
